// File: rtl/lcd_hd44780_model_if.sv
// CPU-side access strobe bundle for the HD44780 model.
// enable (strobe), rnw (1=read), rs (0=cmd/status, 1=data).
interface lcd_hd44780_model_if;
  logic enable;
  logic rnw;
  logic rs;

  modport master (
    output enable,
    output rnw,
    output rs
  );

  modport slave (
    input enable,
    input rnw,
    input rs
  );
endinterface

// File: rtl/lcd_hd44780_model.sv
// HD44780-style LCD model: DDRAM buffer, address counter, timed busy flag.
// Ports: clk, rst_n, bus(enable/rnw/rs), io_bus, out_char/out_valid, overrun, dbg peek.
module lcd_hd44780_model #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int BUSY_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_hd44780_model_if.slave bus,
  inout  wire  [7:0]         io_bus,
  output logic [7:0]         out_char,
  output logic               out_valid,
  output logic               overrun,
  input  logic [6:0]         dbg_addr,
  output logic [7:0]         dbg_data
);

  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FILL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [6:0]      ac_q, ac_d;
  logic            inc_q, inc_d;
  logic            ovr_q, ovr_d;
  logic            valid_q, valid_d;
  logic [7:0]      char_q, char_d;
  logic            enable_q;
  logic            dread_q, dread_d;

  logic [7:0]      mem [2**IW];
  logic            mem_we;
  logic [IW-1:0]   mem_wa;
  logic [7:0]      mem_wd;

  logic            busy;
  logic            ev;
  logic            fall;
  logic            wr_ev;
  logic [7:0]      rd_val;

  function automatic logic mapped(input logic [6:0] a);
    return (int'(a[5:0]) < COLS) && (!a[6] || ROWS == 2);
  endfunction

  // Rows are packed back to back: row 1 starts at index COLS.
  function automatic logic [IW-1:0] idx(input logic [6:0] a);
    int i;
    i = int'(a[5:0]) + (a[6] ? COLS : 0);
    return IW'(i);
  endfunction

  // With at most two rows, "next" and "previous" row are both a toggle.
  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [5:0] col;
    logic       row;
    col = a[5:0];
    row = a[6];
    if (inc) begin
      if (int'(col) >= COLS - 1) begin
        col = '0;
        row = (ROWS == 2) ? ~row : 1'b0;
      end else begin
        col = col + 6'd1;
      end
    end else begin
      if (col == '0) begin
        col = 6'(COLS - 1);
        row = (ROWS == 2) ? ~row : 1'b0;
      end else begin
        col = col - 6'd1;
      end
    end
    return {row, col};
  endfunction

  assign busy  = (state_q != S_IDLE);
  assign ev    = bus.enable && !enable_q;
  assign fall  = !bus.enable && enable_q;
  assign wr_ev = ev && !bus.rnw;

  assign rd_val   = bus.rs ? mem[idx(ac_q)] : {busy, ac_q};
  assign io_bus   = (bus.enable && bus.rnw) ? rd_val : 8'hzz;
  assign dbg_data = mapped(dbg_addr) ? mem[idx(dbg_addr)] : 8'h00;

  assign out_char  = char_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ac_d    = ac_q;
    inc_d   = inc_q;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    char_d  = char_q;
    dread_d = dread_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = 8'h20;

    // Data reads advance AC when the strobe drops, even while busy.
    if (ev && bus.rnw && bus.rs) dread_d = 1'b1;
    if (fall && dread_q) begin
      dread_d = 1'b0;
      ac_d    = ac_step(ac_q, inc_q);
    end

    unique case (state_q)
      S_FILL: begin
        mem_we = 1'b1;
        if (int'(ptr_q) == N - 1) begin
          state_d = S_IDLE;
          ac_d    = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase

    if (wr_ev) begin
      if (busy) begin
        ovr_d = 1'b1;
      end else begin
        state_d = S_BUSY;
        cnt_d   = CW'(BUSY_CYCLES - 1);
        if (bus.rs) begin
          valid_d = 1'b1;
          char_d  = io_bus;
          if (io_bus == 8'h0A) begin
            ac_d = {(ROWS == 2) ? ~ac_q[6] : 1'b0, 6'd0};
          end else begin
            mem_we = 1'b1;
            mem_wa = idx(ac_q);
            mem_wd = io_bus;
            ac_d   = ac_step(ac_q, inc_q);
          end
        end else begin
          unique casez (io_bus)
            8'b1???????: if (mapped(io_bus[6:0])) ac_d = io_bus[6:0];
            8'b00000001: begin
              state_d = S_FILL;
              ptr_d   = '0;
              inc_d   = 1'b1;
            end
            8'b0000001?: ac_d = '0;
            8'b000001??: inc_d = io_bus[1];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ac_q     <= '0;
      inc_q    <= 1'b1;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
      char_q   <= 8'h00;
      enable_q <= 1'b0;
      dread_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      ac_q     <= ac_d;
      inc_q    <= inc_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
      char_q   <= char_d;
      enable_q <= bus.enable;
      dread_q  <= dread_d;
    end
  end

  // Contents are established by the reset-time fill, so no reset here.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: doc/lcd_hd44780_model.md
# lcd_hd44780_model

Parametrised cycle-driven model of an HD44780-style character LCD controller for the emulator's CPU-module set. It sits on the CPU's 8-bit I/O bus behind the display select decode and is strobed by `enable`, with `rnw`/`rs` qualifying each access. Unlike a write-and-trace stub, it holds a DDRAM display buffer, an address counter with entry modes and row wrap, and a timed busy flag driven by a cycle counter. Every accepted data write also appears as a one-cycle character event for the test harness.

## Interface
- `COLS`, 16: characters per row, 1..40
- `ROWS`, 2: rows, 1..2; row r starts at DDRAM address r*0x40
- `BUSY_CYCLES`, 4: busy duration after any accepted write, ≥1
- `clk` in 1: single clock; everything is sampled on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `io_bus` inout 8: CPU data bus
- `enable` in 1: access strobe, active high, synchronous to `clk`
- `rnw` in 1: 1 = read, 0 = write
- `rs` in 1: 0 = command/status, 1 = data
- `out_char` out 8: character of the last accepted data write
- `out_valid` out 1: one-cycle pulse per accepted data write
- `overrun` out 1: sticky; set when a write arrives while busy
- `dbg_addr` in 7: testbench DDRAM peek address
- `dbg_data` out 8: `DDRAM[dbg_addr]`, combinational; 0x00 if the address is unmapped

## Operation
- Access detection: `enable_q` registers `enable`. An access event is `enable && !enable_q`. `rnw`, `rs` and `io_bus` are sampled in that same cycle.
- State machine has three states:
  - IDLE: accepts writes.
  - BUSY: counter loaded with BUSY_CYCLES-1, decrements each cycle, returns to IDLE when it reaches 0.
  - FILL: writes 0x20 to every mapped DDRAM cell, one per cycle (COLS*ROWS cycles), then returns to IDLE with AC = 0.
- Busy flag = (state != IDLE).
- Writes while busy: ignored, `overrun` <= 1, state and counter unchanged.
- Data write, rs=1, in IDLE:
  - 0x0A: AC moves to column 0 of the next row (the last row wraps to row 0). Nothing is stored; `out_valid` pulses with `out_char`=0x0A.
  - Any other byte: stored at DDRAM[AC], `out_valid` pulses, then AC advances per entry mode.
  - Either case then enters BUSY.
- Command write, rs=0, in IDLE, decoded by highest set bit:
  - 0x01 clear: enters FILL and sets the entry mode to increment.
  - 0x02/0x03 home: AC = 0, enters BUSY.
  - 0x04-0x07 entry mode: bit1 = 1 increment, 0 decrement; enters BUSY.
  - 0x80|a set DDRAM address: AC = a if mapped, else AC unchanged; enters BUSY.
  - All other commands: no effect except entering BUSY.
- AC advance with COLS-1 = L:
  - Increment: column L → column 0 of the next row; last row → row 0.
  - Decrement: column 0 → column L of the previous row; row 0 → last row.
- Status read, rs=0, rnw=1: `io_bus` = {busy, AC[6:0]} while `enable && rnw`. It has no side effect.
- Data read, rs=1, rnw=1: `io_bus` = DDRAM[AC] while `enable && rnw`. AC advances on the falling edge of `enable` (`!enable && enable_q`). Data reads are allowed while busy and do not set `overrun`.
- `io_bus` is high-Z whenever `!(enable && rnw)`.

## Timing
- Reset (asynchronous assert): AC=0, increment mode, `out_valid`=0, `out_char`=0x00, `overrun`=0, `enable_q`=0, state=FILL with the fill pointer at 0.
  - After deassert: busy for COLS*ROWS cycles, then IDLE with every cell 0x20.
  - Reset asserted mid-FILL or mid-BUSY restarts FILL from 0.
- Write accepted in cycle N:
  - `out_valid` is high in cycle N+1 only.
  - Busy reads 1 from N+1 through N+BUSY_CYCLES.
  - IDLE is reached in N+BUSY_CYCLES+1.
- Clear accepted in cycle N: busy for cycles N+1..N+COLS*ROWS.
- Status reads are combinational from current state, so a read in the same cycle as an accepted write still shows busy=0.
- An event needs `enable` low for at least one cycle in between. A level held high produces exactly one event.
- DDRAM write and AC update land in the same edge; `dbg_data` reflects the new value in N+1.

## Test plan
- Reset: release `rst_n`, poll status → busy=1 for 32 cycles (16x2), then status = 0x00 and `dbg_data` = 0x20 at 0x00 and 0x4F.
- Write with busy: write data 'A' (0x41) → `out_valid`/`out_char`=0x41 for one cycle, DDRAM[0x00]=0x41, status 0x81 for 4 cycles, then 0x01.
- Overrun: write 'B' during BUSY → DDRAM[0x01] unchanged, `overrun`=1 and held until reset.
- Wrap and newline:
  - Set address 0x0F, write 'X' → AC = 0x40.
  - Write 0x0A → AC = 0x00.
  - Entry mode 0x04, set 0x40, write → AC = 0x0F.
- Data read: set address 0x00, read with rs=1 → `io_bus`=0x41, AC=0x01 after `enable` falls, bus high-Z when `enable`=0.
- Clear: command 0x01 → busy for 32 cycles, all cells 0x20, AC=0. Reset asserted at fill cycle 10 → full 32-cycle fill restarts.
